// File: rtl/mcycle_controller_if.sv
// Control/status bundle between mcycle_controller (master) and the datapath/memory side (slave).
// Carries the latched instruction, flags and memory handshake in, and every control strobe out.
interface mcycle_controller_if;
    logic [15:0] instr;
    logic [7:0]  PSR;
    logic        memReady;
    logic        pcEn;
    logic        instrWrite;
    logic        regWrite;
    logic        psrWrite;
    logic        writeBackSelect;
    logic        dataToWriteSelect;
    logic        pcSrc;
    logic        newAluInput;
    logic [1:0]  aluSrc1Select;
    logic [1:0]  aluSrc2Select;
    logic        memRead;
    logic        memWrite;
    logic        addrSelect;
    logic        halted;
    logic        fault;
    logic [3:0]  state;

    modport master (
        input  instr, PSR, memReady,
        output pcEn, instrWrite, regWrite, psrWrite, writeBackSelect, dataToWriteSelect,
               pcSrc, newAluInput, aluSrc1Select, aluSrc2Select, memRead, memWrite,
               addrSelect, halted, fault, state
    );

    modport slave (
        output instr, PSR, memReady,
        input  pcEn, instrWrite, regWrite, psrWrite, writeBackSelect, dataToWriteSelect,
               pcSrc, newAluInput, aluSrc1Select, aluSrc2Select, memRead, memWrite,
               addrSelect, halted, fault, state
    );
endinterface

// File: rtl/mcycle_controller.sv
// Multicycle fetch/decode/execute control FSM for the 16-bit CR16-style datapath, with memory
// wait handshake and stall timeout. Optional CTRL_HALT_EN makes instr 16'h0000 enter HALT.
module mcycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    mcycle_controller_if.master  bus
);
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_ALU_R  = 4'd2,
        ST_ALU_I  = 4'd3,
        ST_LOAD   = 4'd4,
        ST_STORE  = 4'd5,
        ST_BRANCH = 4'd6,
        ST_JUMP   = 4'd7,
        ST_HALT   = 4'd8,
        ST_FAULT  = 4'd9
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 32'd1);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [3:0]  opcode_s, ext_s, cond_s;
    logic        mem_state_s;
    logic        cond_true_s;
    logic        unused_bits_s;

    assign opcode_s      = bus.instr[15:12];
    assign ext_s         = bus.instr[7:4];
    assign cond_s        = bus.instr[11:8];
    assign mem_state_s   = (state_q == ST_FETCH) || (state_q == ST_LOAD) || (state_q == ST_STORE);
    assign cond_true_s   = cond_met(cond_s, bus.PSR);
    assign unused_bits_s = ^{bus.instr[3:0], bus.PSR[4:3], bus.PSR[1]};

    // Flags: C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7.
    function automatic logic cond_met(input logic [3:0] cond, input logic [7:0] psr);
        logic c, l, f, z, n, r;
        c = psr[0];
        l = psr[2];
        f = psr[5];
        z = psr[6];
        n = psr[7];
        case (cond)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = c;
            4'd3:    r = !c;
            4'd4:    r = l;
            4'd5:    r = !l;
            4'd6:    r = n;
            4'd7:    r = !n;
            4'd8:    r = f;
            4'd9:    r = !f;
            4'd10:   r = !l && !z;
            4'd11:   r = l || z;
            4'd12:   r = !n && !z;
            4'd13:   r = n || z;
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state selection and memory stall counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_FETCH: begin
                if (bus.memReady)                      state_d = ST_DECODE;
                else if (wait_cnt_q == TIMEOUT_LAST)   state_d = ST_FAULT;
                else                                   state_d = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode_s)
                    4'b0000: begin
`ifdef CTRL_HALT_EN
                        if (bus.instr == 16'h0000) state_d = ST_HALT;
                        else                       state_d = ST_ALU_R;
`else
                        state_d = ST_ALU_R;
`endif
                    end
                    4'b0100: begin
                        case (ext_s)
                            4'b0000: state_d = ST_LOAD;
                            4'b0100: state_d = ST_STORE;
                            4'b1000: state_d = ST_JUMP;
                            4'b1100: state_d = ST_JUMP;
                            default: state_d = ST_FETCH;
                        endcase
                    end
                    4'b1100: state_d = ST_BRANCH;
                    default: state_d = ST_ALU_I;
                endcase
            end
            ST_ALU_R, ST_ALU_I, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_LOAD, ST_STORE: begin
                if (bus.memReady)                      state_d = ST_FETCH;
                else if (wait_cnt_q == TIMEOUT_LAST)   state_d = ST_FAULT;
                else                                   state_d = state_q;
            end
            ST_HALT:  state_d = ST_HALT;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase

        if (state_d != state_q)              wait_cnt_d = 8'd0;
        else if (mem_state_s && !bus.memReady) wait_cnt_d = wait_cnt_q + 8'd1;
        else                                 wait_cnt_d = wait_cnt_q;
    end

    // Control outputs decoded from state and live inputs; all forced low while reset is high.
    always_comb begin
        bus.pcEn              = 1'b0;
        bus.instrWrite        = 1'b0;
        bus.regWrite          = 1'b0;
        bus.psrWrite          = 1'b0;
        bus.writeBackSelect   = 1'b0;
        bus.dataToWriteSelect = 1'b0;
        bus.pcSrc             = 1'b0;
        bus.newAluInput       = 1'b0;
        bus.aluSrc1Select     = 2'b00;
        bus.aluSrc2Select     = 2'b00;
        bus.memRead           = 1'b0;
        bus.memWrite          = 1'b0;
        bus.addrSelect        = 1'b0;
        bus.halted            = 1'b0;
        bus.fault             = 1'b0;
        bus.state             = 4'd0;
        if (!reset) begin
            bus.state = state_q;
            case (state_q)
                ST_FETCH: begin
                    bus.memRead    = 1'b1;
                    bus.instrWrite = bus.memReady;
                end
                ST_DECODE: begin
                    bus.newAluInput   = 1'b1;
                    bus.pcEn          = 1'b1;
                    bus.aluSrc2Select = 2'b10;
                end
                ST_ALU_R: begin
                    bus.aluSrc1Select = 2'b01;
                    bus.psrWrite      = 1'b1;
                    bus.regWrite      = (ext_s != 4'b1011);
                end
                ST_ALU_I: begin
                    bus.aluSrc1Select = 2'b01;
                    bus.aluSrc2Select = 2'b01;
                    bus.psrWrite      = 1'b1;
                    bus.regWrite      = (opcode_s != 4'b1011);
                end
                ST_LOAD: begin
                    bus.memRead         = 1'b1;
                    bus.addrSelect      = 1'b1;
                    bus.regWrite        = bus.memReady;
                    bus.writeBackSelect = bus.memReady;
                end
                ST_STORE: begin
                    bus.memWrite   = 1'b1;
                    bus.addrSelect = 1'b1;
                end
                ST_BRANCH: begin
                    bus.pcEn          = cond_true_s;
                    bus.aluSrc2Select = cond_true_s ? 2'b11 : 2'b00;
                end
                ST_JUMP: begin
                    // JAL (ext 1000) links and jumps unconditionally; Jcond only jumps.
                    bus.pcEn              = (ext_s == 4'b1000) || cond_true_s;
                    bus.pcSrc             = (ext_s == 4'b1000) || cond_true_s;
                    bus.regWrite          = (ext_s == 4'b1000);
                    bus.dataToWriteSelect = (ext_s == 4'b1000);
                end
                ST_HALT: bus.halted = 1'b1;
                ST_FAULT: begin
                    bus.halted = 1'b1;
                    bus.fault  = 1'b1;
                end
                default: begin
                    bus.halted = 1'b1;
                    bus.fault  = 1'b1;
                end
            endcase
        end else begin
            bus.state = 4'd0;
        end
    end

    // State and stall counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end
endmodule

// File: tb/tb_mcycle_controller.sv
// Directed table-driven bench for mcycle_controller (MEM_TIMEOUT=4), plus hand sequences for
// the HALT/ALU_R decode of 16'h0000, stall timeout into FAULT, and reset out of FAULT.
module tb_mcycle_controller;
    typedef struct packed {
        logic [3:0] st;
        logic       pc_en, instr_wr, reg_wr, psr_wr, wb_sel, dtw_sel, pc_src, new_alu;
        logic [1:0] a1, a2;
        logic       mem_rd, mem_wr, addr_sel, halted, fault;
    } outs_t;

    typedef struct {
        string       name;
        logic [15:0] instr;
        logic [7:0]  psr;
        logic        mr;
        outs_t       exp;
    } rec_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    rec_t tbl[$];
    outs_t FW, FR, DE, AI, AR, ACMP, LW, LR, BT, BN, JL, SW, JN, HL, FT, Z0;

    mcycle_controller_if bus ();
    mcycle_controller #(.MEM_TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t mk(input logic [3:0] st, input logic pc_en, input logic iw,
                                 input logic rw, input logic pw, input logic wb, input logic dtw,
                                 input logic pcs, input logic nai, input logic [1:0] a1,
                                 input logic [1:0] a2, input logic mrd, input logic mwr,
                                 input logic as, input logic hl, input logic ft);
        outs_t o;
        o.st = st; o.pc_en = pc_en; o.instr_wr = iw; o.reg_wr = rw; o.psr_wr = pw;
        o.wb_sel = wb; o.dtw_sel = dtw; o.pc_src = pcs; o.new_alu = nai; o.a1 = a1; o.a2 = a2;
        o.mem_rd = mrd; o.mem_wr = mwr; o.addr_sel = as; o.halted = hl; o.fault = ft;
        return o;
    endfunction

    function automatic outs_t sample();
        return mk(bus.state, bus.pcEn, bus.instrWrite, bus.regWrite, bus.psrWrite,
                  bus.writeBackSelect, bus.dataToWriteSelect, bus.pcSrc, bus.newAluInput,
                  bus.aluSrc1Select, bus.aluSrc2Select, bus.memRead, bus.memWrite,
                  bus.addrSelect, bus.halted, bus.fault);
    endfunction

    task automatic chk(input string name, input outs_t exp);
        outs_t act;
        act = sample();
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input string name, input logic [15:0] instr, input logic [7:0] psr,
                       input logic mr, input outs_t exp);
        rec_t r;
        r.name = name; r.instr = instr; r.psr = psr; r.mr = mr; r.exp = exp;
        tbl.push_back(r);
    endtask

    task automatic drive(input logic [15:0] instr, input logic [7:0] psr, input logic mr);
        bus.instr    = instr;
        bus.PSR      = psr;
        bus.memReady = mr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        //       st     pc iw rw pw wb dt ps na a1     a2     mr mw as hl ft
        FW   = mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        FR   = mk(4'd0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 0);
        DE   = mk(4'd1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0, 0, 0);
        AI   = mk(4'd3, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b01, 0, 0, 0, 0, 0);
        AR   = mk(4'd2, 0, 0, 1, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        ACMP = mk(4'd2, 0, 0, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        LW   = mk(4'd4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0);
        LR   = mk(4'd4, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 1, 0, 1, 0, 0);
        BT   = mk(4'd6, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b11, 0, 0, 0, 0, 0);
        BN   = mk(4'd6, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        JL   = mk(4'd7, 1, 0, 1, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        SW   = mk(4'd5, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 1, 0, 0);
        JN   = mk(4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        HL   = mk(4'd8, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 0);
        FT   = mk(4'd9, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 1, 1);
        Z0   = mk(4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0);

        add("addi_fetch",  16'h510A, 8'h00, 1'b1, FR);
        add("addi_decode", 16'h510A, 8'h00, 1'b1, DE);
        add("addi_exec",   16'h510A, 8'h00, 1'b1, AI);
        add("cmp_fetch",   16'h02B1, 8'h00, 1'b1, FR);
        add("cmp_decode",  16'h02B1, 8'h00, 1'b1, DE);
        add("cmp_exec",    16'h02B1, 8'h00, 1'b1, ACMP);
        add("ld_fetch",    16'h4102, 8'h00, 1'b1, FR);
        add("ld_decode",   16'h4102, 8'h00, 1'b1, DE);
        add("ld_wait1",    16'h4102, 8'h00, 1'b0, LW);
        add("ld_wait2",    16'h4102, 8'h00, 1'b0, LW);
        add("ld_wait3",    16'h4102, 8'h00, 1'b0, LW);
        add("ld_done",     16'h4102, 8'h00, 1'b1, LR);
        add("beq_t_fetch", 16'hC0FE, 8'h40, 1'b1, FR);
        add("beq_t_dec",   16'hC0FE, 8'h40, 1'b1, DE);
        add("beq_taken",   16'hC0FE, 8'h40, 1'b1, BT);
        add("beq_n_fetch", 16'hC0FE, 8'h00, 1'b1, FR);
        add("beq_n_dec",   16'hC0FE, 8'h00, 1'b1, DE);
        add("beq_not",     16'hC0FE, 8'h00, 1'b1, BN);
        add("jal_fetch",   16'h4E83, 8'h00, 1'b1, FR);
        add("jal_decode",  16'h4E83, 8'h00, 1'b1, DE);
        add("jal_exec",    16'h4E83, 8'h00, 1'b1, JL);
        add("st_fetch",    16'h4143, 8'h00, 1'b1, FR);
        add("st_decode",   16'h4143, 8'h00, 1'b1, DE);
        add("st_wait",     16'h4143, 8'h00, 1'b0, SW);
        add("st_done",     16'h4143, 8'h00, 1'b1, SW);
        add("jne_fetch",   16'h41C3, 8'h40, 1'b1, FR);
        add("jne_decode",  16'h41C3, 8'h40, 1'b1, DE);
        add("jne_not",     16'h41C3, 8'h40, 1'b1, JN);
        add("nop_fetch",   16'h4020, 8'h00, 1'b1, FR);
        add("nop_decode",  16'h4020, 8'h00, 1'b1, DE);
        add("stall1",      16'h0000, 8'h00, 1'b0, FW);
        add("stall2",      16'h0000, 8'h00, 1'b0, FW);
        add("stall3",      16'h0000, 8'h00, 1'b0, FW);
        add("stall_last",  16'h0000, 8'h00, 1'b1, FR);

        reset = 1'b1;
        drive(16'h510A, 8'h00, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", Z0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].instr, tbl[i].psr, tbl[i].mr);
            @(negedge clk);
            chk(tbl[i].name, tbl[i].exp);
            @(posedge clk);
            #1;
        end

        // 16'h0000 reached DECODE; what follows depends on the HALT option.
        drive(16'h0000, 8'h00, 1'b0);
        @(negedge clk);
        chk("zero_decode", DE);
        @(posedge clk);
        #1;
        @(negedge clk);
`ifdef CTRL_HALT_EN
        chk("zero_halt", HL);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("halt_stays", HL);
`else
        chk("zero_alu_r", AR);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("zero_back_fetch", FW);
`endif

        // Fresh reset, then memReady stuck low in FETCH: FAULT after 4 stalled cycles.
        #2 reset = 1'b1;
        #1 chk("reset_async", Z0);
        @(posedge clk);
        #1 reset = 1'b0;
        drive(16'h510A, 8'h00, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("to_stall%0d", k), FW);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("fault_entered", FT);
        bus.memReady = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("fault_sticky", FT);
        #2 reset = 1'b1;
        #1 chk("fault_reset_async", Z0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("fetch_after_reset", FR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mcycle_controller.md
# mcycle_controller

Multicycle control FSM for the 16-bit CR16-style `datapath`. It sequences fetch, decode, execute, memory and writeback by driving every datapath control input (`pcEn`, `instrWrite`, `regWrite`, mux selects, `newAluInput`) from the latched `instr` and `PSR`. It also drives the memory read/write strobes with a `memReady` wait handshake and a stall timeout. It sits between `datapath` and the unified instruction/data memory, and replaces hand-driven control in datapath benches.

## Interface
- `MEM_TIMEOUT`, 15: consecutive `memReady`-low cycles tolerated in a memory state before entering FAULT; legal range 1–255.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high; one clock; reset is asynchronous and active-high.
- `instr` in 16: instruction register contents from `datapath`.
- `PSR` in 8: flags, with C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7.
- `memReady` in 1: memory completes the current access this cycle.
- `pcEn` out 1: PC write enable.
- `instrWrite` out 1: load IR from `memDataInbound`.
- `regWrite` out 1: register file write.
- `psrWrite` out 1: PSR update from ALU flags.
- `writeBackSelect` out 1: 0 = ALU result, 1 = memory data.
- `dataToWriteSelect` out 1: 0 = writeback path, 1 = PC (link).
- `pcSrc` out 1: 0 = ALU result, 1 = Rsrc register.
- `newAluInput` out 1: latch ALU operand registers.
- `aluSrc1Select` out 2: 00 = PC, 01 = Rdest.
- `aluSrc2Select` out 2: 00 = Rsrc, 01 = sign-extended imm8, 10 = +1, 11 = sign-extended disp8.
- `memRead`, `memWrite` out 1 each: memory strobes.
- `addrSelect` out 1: `memAddr` source; 0 = PC, 1 = Rsrc.
- `halted` out 1: FSM in HALT or FAULT.
- `fault` out 1: FSM in FAULT.
- `state` out 4: current state encoding.

## Operation
- States: FETCH=0, DECODE=1, ALU_R=2, ALU_I=3, LOAD=4, STORE=5, BRANCH=6, JUMP=7, HALT=8, FAULT=9.
- Unlisted outputs are 0 in every state. Outputs are combinational from `state`, `instr`, `PSR` and `memReady`.
- FETCH
  - Drives `memRead`=1 and `addrSelect`=0.
  - When `memReady`=1: drives `instrWrite`=1 and moves to DECODE. Otherwise it stays in FETCH.
- DECODE
  - Drives `newAluInput`=1, `pcEn`=1, `aluSrc1Select`=00, `aluSrc2Select`=10 and `pcSrc`=0, so PC←PC+1.
  - Dispatch on opcode `instr[15:12]` and ext `instr[7:4]`:
    - 0000 → ALU_R.
    - 0100: ext 0000 → LOAD; ext 0100 → STORE; ext 1000 or 1100 → JUMP; any other ext → FETCH (NOP).
    - 1100 → BRANCH.
    - Any other opcode → ALU_I.
- ALU_R
  - Drives `aluSrc1Select`=01, `aluSrc2Select`=00 and `psrWrite`=1.
  - Drives `regWrite`=1 unless ext=1011 (CMP).
  - Next state: FETCH.
- ALU_I
  - Same as ALU_R, but `aluSrc2Select`=01.
  - `regWrite` is suppressed for opcode 1011 (CMPI).
  - Next state: FETCH.
- LOAD
  - Drives `memRead`=1 and `addrSelect`=1.
  - On `memReady`: drives `regWrite`=1 and `writeBackSelect`=1, then moves to FETCH.
- STORE
  - Drives `memWrite`=1 and `addrSelect`=1.
  - On `memReady`: moves to FETCH.
- BRANCH
  - Condition field is `instr[11:8]`.
  - If the condition is true: drives `pcEn`=1, `aluSrc1Select`=00, `aluSrc2Select`=11. Target = (PC+1) + sext(`instr[7:0]`).
  - Next state: FETCH.
- JUMP
  - Jcond (ext 1100): if the condition `instr[11:8]` is true, drives `pcEn`=1 and `pcSrc`=1.
  - JAL (ext 1000), unconditional: drives `regWrite`=1, `dataToWriteSelect`=1, `pcEn`=1 and `pcSrc`=1.
  - Next state: FETCH.
- Condition codes:
  - 0 EQ: Z. 1 NE: !Z. 2 CS: C. 3 CC: !C.
  - 4 HI: L. 5 LS: !L. 6 GT: N. 7 LE: !N.
  - 8 FS: F. 9 FC: !F.
  - 10 LO: !L&!Z. 11 HS: L|Z. 12 LT: !N&!Z. 13 GE: N|Z.
  - 14 UC: always. 15: never.
- Stall timeout:
  - An 8-bit wait counter clears on entry to FETCH, LOAD or STORE and increments on each cycle in that state with `memReady`=0.
  - When `memReady`=0 and count = `MEM_TIMEOUT`-1, the next state is FAULT.
  - `memReady`=1 in that same cycle wins, and the normal transition is taken.
- FAULT: all strobes are 0 and `halted`=`fault`=1. FAULT is left only by `reset`.

## Timing
- Reset asserted: state=FETCH, wait counter=0. All outputs are forced to 0 while `reset`=1, including `memRead`. Reset abandons any in-flight access immediately.
- First cycle after reset release: FETCH with `memRead`=1.
- Cycle counts with `memReady` high on first request:
  - ALU, branch, jump and NOP: 3 cycles (FETCH, DECODE, execute).
  - LOAD and STORE: 3 cycles.
- Each low-`memReady` cycle adds one cycle.
- `regWrite` and `pcEn` are single-cycle pulses. The register/PC update occurs at the rising edge ending the asserting cycle.

## Configuration
- `CTRL_HALT_EN` defined: `instr`=16'h0000 decoded in DECODE goes to HALT. HALT asserts `halted`=1, drives no strobes, and stays there until `reset`. DECODE's PC increment still happens.
- `CTRL_HALT_EN` undefined: 16'h0000 is an ordinary ALU_R instruction, and the HALT state is unreachable.

## Test plan
- ADDI: `instr`=16'h510A, `memReady` held 1.
  - Required: `state` sequence 0,1,3,0.
  - In the ALU_I cycle: `regWrite`=1, `psrWrite`=1, `aluSrc1Select`=01, `aluSrc2Select`=01.
- CMP: `instr`=16'h02B1.
  - Required: ALU_R with `psrWrite`=1 and `regWrite`=0.
- LOAD with wait states: `instr`=16'h4102, `memReady`=0 for 3 cycles in LOAD, then 1.
  - Required: LOAD held 4 cycles; `regWrite`=`writeBackSelect`=1 only in the last of them.
- Bcond: BEQ `instr`=16'hC0FE.
  - With `PSR`=8'h40 (Z set): `pcEn`=1 and `aluSrc2Select`=11 in BRANCH.
  - With `PSR`=8'h00: `pcEn`=0 in BRANCH.
- JAL `instr`=16'h4E83.
  - Required: in JUMP, `regWrite`=1, `dataToWriteSelect`=1, `pcEn`=1, `pcSrc`=1.
- Timeout, `MEM_TIMEOUT`=4, `memReady` stuck 0 in FETCH.
  - Required: FAULT entered after 4 stalled cycles, with `fault`=`halted`=1.
  - Assert `reset` mid-fault: outputs go to 0 immediately, and FETCH resumes after release.
